// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI master that sends a CMD_W-bit command MSB first, then
// optionally reads rd_count words of RD_W bits in the same chip-select window.
// Optional build macro SPI_CMD_MASTER_MODE3_EN selects CPOL=1/CPHA=1. When the
// macro is undefined the block runs in mode 0 (CPOL=0/CPHA=0).
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   start               transaction request, sampled only while busy=0
//   cmd_data, rd_count  command frame and read word count, latched on accept
//   data_out, rd_valid  last received word and its one-cycle update strobe
//   busy, done          transaction in progress / one-cycle end pulse
//   spi_cs_n, spi_sclk, spi_mosi, spi_miso   SPI pins (miso synchronous to clk)
module spi_cmd_master #(
   parameter int unsigned CMD_W  = 32,
   parameter int unsigned RD_W   = 8,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned DIV    = 2,
   parameter int unsigned CS_GAP = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CMD_W-1:0] cmd_data,
   input  logic [CNT_W-1:0] rd_count,
   output logic [RD_W-1:0]  data_out,
   output logic             rd_valid,
   output logic             busy,
   output logic             done,
   output logic             spi_cs_n,
   output logic             spi_sclk,
   output logic             spi_mosi,
   input  logic             spi_miso
);

`ifdef SPI_CMD_MASTER_MODE3_EN
   localparam bit   MODE3     = 1'b1;
   localparam logic SCLK_IDLE = 1'b1;
`else
   localparam bit   MODE3     = 1'b0;
   localparam logic SCLK_IDLE = 1'b0;
`endif

   localparam int unsigned BIT_MAX = (CMD_W > RD_W) ? CMD_W : RD_W;
   localparam int unsigned BIT_W   = $clog2(BIT_MAX) + 1;
   localparam int unsigned DIV_W   = $clog2(DIV) + 1;
   localparam int unsigned GAP_W   = $clog2(CS_GAP) + 1;

   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);
   localparam logic [BIT_W-1:0] CMD_LOAD = BIT_W'(CMD_W - 1);
   localparam logic [BIT_W-1:0] RD_LOAD  = BIT_W'(RD_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETUP, ST_SEND, ST_RECV, ST_HOLD, ST_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               half_q, half_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [CNT_W-1:0]   word_q, word_d;
   logic [CNT_W-1:0]   rdn_q, rdn_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [CMD_W-1:0]   cmd_q, cmd_d;
   logic [RD_W-1:0]    shreg_q, shreg_d;
   logic               pend_q, pend_d;
   logic [RD_W-1:0]    data_out_q, data_out_d;
   logic               rd_valid_q, rd_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cs_n_q, cs_n_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;

   logic in_bits_c, div_last_c, lead_c, trail_c, sample_c, drive_c;

   // Bit-phase edges: leading edge enters the active sclk level, trailing edge ends the bit
   assign in_bits_c  = (state_q == ST_SEND) || (state_q == ST_RECV);
   assign div_last_c = (div_q == '0);
   assign lead_c     = in_bits_c && div_last_c && !half_q;
   assign trail_c    = in_bits_c && div_last_c && half_q;
   assign sample_c   = MODE3 ? trail_c : lead_c;
   assign drive_c    = MODE3 ? lead_c  : trail_c;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      half_d     = half_q;
      bit_d      = bit_q;
      word_d     = word_q;
      rdn_d      = rdn_q;
      gap_d      = gap_q;
      cmd_d      = cmd_q;
      shreg_d    = shreg_q;
      pend_d     = 1'b0;
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      cs_n_d     = cs_n_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;

      // A completed word is published one cycle after its last sample
      if (pend_q) begin
         data_out_d = shreg_q;
         rd_valid_d = 1'b1;
      end

      if (sample_c && (state_q == ST_RECV)) begin
         shreg_d = RD_W'({shreg_q, spi_miso});
         pend_d  = (bit_q == '0);
      end

      // Mode 0 drives the next bit at the end of a bit; mode 3 drives the current bit mid-bit
      if (drive_c) begin
         if ((state_q == ST_SEND) && (MODE3 || (bit_q != '0))) begin
            mosi_d = cmd_q[CMD_W-1];
            cmd_d  = cmd_q << 1;
         end else begin
            mosi_d = 1'b0;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start && !busy_q) begin
               state_d = ST_SETUP;
               rdn_d   = rd_count;
               div_d   = DIV_LOAD;
               half_d  = 1'b0;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               sclk_d  = SCLK_IDLE;
               if (MODE3) begin
                  cmd_d  = cmd_data;
                  mosi_d = 1'b0;
               end else begin
                  cmd_d  = cmd_data << 1;
                  mosi_d = cmd_data[CMD_W-1];
               end
            end
         end
         ST_SETUP: begin
            if (div_last_c) begin
               state_d = ST_SEND;
               div_d   = DIV_LOAD;
               half_d  = 1'b0;
               bit_d   = CMD_LOAD;
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         ST_SEND, ST_RECV: begin
            if (!div_last_c) begin
               div_d = div_q - 1'b1;
            end else begin
               div_d  = DIV_LOAD;
               half_d = ~half_q;
               sclk_d = half_q ? SCLK_IDLE : ~SCLK_IDLE;
               if (half_q) begin
                  // End of bit: advance bit/word counters or change phase
                  if (bit_q != '0) begin
                     bit_d = bit_q - 1'b1;
                  end else if ((state_q == ST_SEND) && (rdn_q != '0)) begin
                     state_d = ST_RECV;
                     bit_d   = RD_LOAD;
                     word_d  = rdn_q - 1'b1;
                  end else if ((state_q == ST_RECV) && (word_q != '0)) begin
                     bit_d  = RD_LOAD;
                     word_d = word_q - 1'b1;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (div_last_c) begin
               state_d = ST_GAP;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               gap_d   = GAP_LOAD;
               done_d  = (CS_GAP == 1);
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_d  = gap_q - 1'b1;
               done_d = (gap_q == GAP_W'(1));
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         half_q     <= 1'b0;
         bit_q      <= '0;
         word_q     <= '0;
         rdn_q      <= '0;
         gap_q      <= '0;
         cmd_q      <= '0;
         shreg_q    <= '0;
         pend_q     <= 1'b0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         sclk_q     <= SCLK_IDLE;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         half_q     <= half_d;
         bit_q      <= bit_d;
         word_q     <= word_d;
         rdn_q      <= rdn_d;
         gap_q      <= gap_d;
         cmd_q      <= cmd_d;
         shreg_q    <= shreg_d;
         pend_q     <= pend_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cs_n_q     <= cs_n_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
      end
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign spi_cs_n = cs_n_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
`timescale 1ns/1ps
module tb_spi_cmd_master;

`ifdef SPI_CMD_MASTER_MODE3_EN
   localparam logic SCLK_IDLE = 1'b1;
   localparam logic MOSI_A5_SETUP = 1'b0;
`else
   localparam logic SCLK_IDLE = 1'b0;
   localparam logic MOSI_A5_SETUP = 1'b1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   // 8-bit command instance
   logic       start8;
   logic [7:0] cmd8, rd8, dout8;
   logic       rdv8, busy8, done8, cs8, sclk8, mosi8;

   // 32-bit command instance
   logic        start32;
   logic [31:0] cmd32;
   logic [7:0]  rd32, dout32;
   logic        rdv32, busy32, done32, cs32, sclk32, mosi32, miso32;

   spi_cmd_master #(.CMD_W(8), .RD_W(8), .CNT_W(8), .DIV(2), .CS_GAP(2)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .cmd_data(cmd8), .rd_count(rd8),
      .data_out(dout8), .rd_valid(rdv8), .busy(busy8), .done(done8),
      .spi_cs_n(cs8), .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_miso(1'b0));

   spi_cmd_master #(.CMD_W(32), .RD_W(8), .CNT_W(8), .DIV(2), .CS_GAP(2)) u_dut32 (
      .clk(clk), .reset(reset), .start(start32), .cmd_data(cmd32), .rd_count(rd32),
      .data_out(dout32), .rd_valid(rdv32), .busy(busy32), .done(done32),
      .spi_cs_n(cs32), .spi_sclk(sclk32), .spi_mosi(mosi32), .spi_miso(miso32));

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Slave model: bit stream for miso, scoreboard of expected read words
   logic       miso_stream[$];
   logic [7:0] sb[$];

   function automatic logic peek();
      if (miso_stream.size() > 0) return miso_stream[0];
      return 1'b0;
   endfunction

   task automatic push_zeros(input int n);
      repeat (n) miso_stream.push_back(1'b0);
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) miso_stream.push_back(w[i]);
      sb.push_back(w);
   endtask

   // Monitors for the 8-bit instance
   int cs_low8 = 0, pulses8 = 0, done_n8 = 0;
   logic [7:0] cap8 = '0;
   always @(negedge clk) begin
      if (cs8 === 1'b0) cs_low8++;
      if (done8 === 1'b1) done_n8++;
      if (rdv8 === 1'b1) check("rd_valid8_extra", 1, 0);
   end
   always @(posedge sclk8) if (cs8 === 1'b0) begin
      pulses8++;
      cap8 = {cap8[6:0], mosi8};
   end

   // Monitors for the 32-bit instance
   int cs_low = 0, pulses = 0, done_n = 0, rdv_n = 0, windows = 0;
   int bit_idx = 0, hi_run = 0, min_gap = 1000;
   logic [31:0] cap = '0;

   // Slave shifts on falling sclk (and presents first bit at cs_n fall); consumes on rising
   always @(negedge cs32 or negedge sclk32) if (cs32 === 1'b0) miso32 = peek();
   always @(negedge cs32) begin
      windows++;
      bit_idx = 0;
   end
   always @(posedge sclk32) if (cs32 === 1'b0) begin
      pulses++;
      if (bit_idx < 32) cap = {cap[30:0], mosi32};
      bit_idx++;
      if (miso_stream.size() > 0) void'(miso_stream.pop_front());
   end

   always @(negedge clk) begin
      if (cs32 === 1'b0) begin
         cs_low++;
         if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
         hi_run = 0;
      end else begin
         hi_run++;
      end
      if (done32 === 1'b1) done_n++;
      if (rdv32 === 1'b1) begin
         rdv_n++;
         if (sb.size() == 0) check("rd_valid_extra", 1, 0);
         else check("data_out", dout32, sb.pop_front());
      end
      if (reset === 1'b1 && cs32 === 1'b1) check("sclk_idle_cs_high", sclk32, SCLK_IDLE);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clear_counts();
      cs_low = 0; pulses = 0; done_n = 0; rdv_n = 0; windows = 0;
   endtask

   task automatic wait_done32(input string tag, input int max);
      int n;
      n = 0;
      while (done32 !== 1'b1 && n < max) begin
         tick(1);
         n++;
      end
      check(tag, done32, 1'b1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, n;
      reset = 1'b0; start8 = 1'b0; cmd8 = '0; rd8 = '0;
      start32 = 1'b0; cmd32 = '0; rd32 = '0;
      tick(3);
      check("rst_cs_n", cs32, 1'b1);
      check("rst_sclk", sclk32, SCLK_IDLE);
      check("rst_mosi", mosi32, 1'b0);
      check("rst_busy", busy32, 1'b0);
      check("rst_done", done32, 1'b0);
      check("rst_rd_valid", rdv32, 1'b0);
      check("rst_data_out", dout32, 8'h00);
      check("rst_cs_n8", cs8, 1'b1);
      reset = 1'b1;
      tick(2);

      // Test 1: write-only 8-bit command 0xA5
      cs_low8 = 0; pulses8 = 0; done_n8 = 0;
      cmd8 = 8'hA5; rd8 = 8'd0; start8 = 1'b1;
      tick(1);
      start8 = 1'b0;
      check("t1_busy", busy8, 1'b1);
      check("t1_cs_low", cs8, 1'b0);
      check("t1_mosi_setup", mosi8, MOSI_A5_SETUP);
      n = 0;
      while (done8 !== 1'b1 && n < 100) begin tick(1); n++; end
      check("t1_done", done8, 1'b1);
      tick(5);
      check("t1_cs_cycles", cs_low8, 36);
      check("t1_pulses", pulses8, 8);
      check("t1_mosi_bits", cap8, 8'hA5);
      check("t1_done_count", done_n8, 1);
      check("t1_idle_busy", busy8, 1'b0);

      // Test 2: 32-bit command, read 0x3C and 0xC3; rd_count changed after accept
      clear_counts(); miso_stream.delete(); sb.delete();
      push_zeros(32); push_word(8'h3C); push_word(8'hC3);
      cmd32 = 32'h9000_0001; rd32 = 8'd2; start32 = 1'b1;
      tick(1);
      start32 = 1'b0; rd32 = 8'd0;
      wait_done32("t2_done", 400);
      tick(5);
      check("t2_pulses", pulses, 48);
      check("t2_rd_valid_count", rdv_n, 2);
      check("t2_mosi_cmd", cap, 32'h9000_0001);
      check("t2_cs_cycles", cs_low, 196);
      check("t2_done_count", done_n, 1);
      check("t2_sb_empty", sb.size(), 0);
      check("t2_data_held", dout32, 8'hC3);

      // Test 3: start while busy is ignored
      clear_counts(); miso_stream.delete(); sb.delete();
      cmd32 = 32'h1234_5678; rd32 = 8'd0; start32 = 1'b1;
      tick(1);
      start32 = 1'b0;
      tick(4);
      check("t3_busy", busy32, 1'b1);
      cmd32 = 32'hFFFF_FFFF; rd32 = 8'd3; start32 = 1'b1;
      tick(1);
      start32 = 1'b0;
      wait_done32("t3_done", 300);
      tick(30);
      check("t3_windows", windows, 1);
      check("t3_done_count", done_n, 1);
      check("t3_mosi_cmd", cap, 32'h1234_5678);
      check("t3_rd_valid_count", rdv_n, 0);
      check("t3_cs_cycles", cs_low, 132);
      check("t3_idle_busy", busy32, 1'b0);

      // Test 4: reset in the middle of the read phase
      clear_counts(); miso_stream.delete(); sb.delete();
      cmd32 = 32'hA5A5_A5A5; rd32 = 8'd2; start32 = 1'b1;
      tick(1);
      start32 = 1'b0;
      tick(136);
      check("t4_busy_before", busy32, 1'b1);
      check("t4_cs_before", cs32, 1'b0);
      reset = 1'b0;
      tick(1);
      check("t4_cs_n", cs32, 1'b1);
      check("t4_busy", busy32, 1'b0);
      check("t4_sclk", sclk32, SCLK_IDLE);
      check("t4_done", done32, 1'b0);
      check("t4_rd_valid", rdv32, 1'b0);
      tick(1);
      reset = 1'b1;
      tick(20);
      check("t4_no_done", done_n, 0);
      check("t4_no_rd_valid", rdv_n, 0);

      clear_counts(); miso_stream.delete(); sb.delete();
      push_zeros(32); push_word(8'h5A);
      cmd32 = 32'h0000_0003; rd32 = 8'd1; start32 = 1'b1;
      tick(1);
      start32 = 1'b0;
      wait_done32("t4_clean_done", 400);
      tick(5);
      check("t4_clean_rd_valid", rdv_n, 1);
      check("t4_clean_data", dout32, 8'h5A);
      check("t4_clean_pulses", pulses, 40);
      check("t4_clean_cs_cycles", cs_low, 164);
      check("t4_clean_done_count", done_n, 1);
      check("t4_clean_mosi_cmd", cap, 32'h0000_0003);

      // Test 5: start held high gives back-to-back frames
      clear_counts(); miso_stream.delete(); sb.delete();
      push_zeros(32); push_word(8'h11);
      push_zeros(32); push_word(8'h22);
      push_zeros(32); push_word(8'h33);
      min_gap = 1000;
      cmd32 = 32'h0BAD_F00D; rd32 = 8'd1; start32 = 1'b1;
      k = 0; n = 0;
      while (k < 3 && n < 1000) begin
         tick(1);
         n++;
         if (done32 === 1'b1) k++;
      end
      start32 = 1'b0;
      check("t5_frames_done", k, 3);
      tick(30);
      check("t5_windows", windows, 3);
      check("t5_rd_valid_count", rdv_n, 3);
      check("t5_done_count", done_n, 3);
      check("t5_min_cs_gap", min_gap, 3);
      check("t5_sb_empty", sb.size(), 0);
      check("t5_mosi_cmd", cap, 32'h0BAD_F00D);
      check("t5_idle_busy", busy32, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
